// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side push channel, flush, and decoded head-entry bundle for decode_pipe.
// Latency: none; the interface carries wires only.
// Backpressure: in_ready/out_ready form the valid-ready handshakes on either side.
interface decode_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_branch;
  logic            out_jump;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_memtoreg;
  logic            out_alu_src;
  logic            out_write_enable;
  logic [1:0]      out_pc_sel;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  // Driver side: fetch plus execute-side consumer (testbench or surrounding pipeline).
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
    input  out_branch, out_jump, out_mem_read, out_mem_write, out_memtoreg,
    input  out_alu_src, out_write_enable, out_pc_sel, out_alu_op, out_imm, out_illegal
  );

  // Decoder side.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
    output out_branch, out_jump, out_mem_read, out_mem_write, out_memtoreg,
    output out_alu_src, out_write_enable, out_pc_sel, out_alu_op, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: decodes RV32I-style instructions at push time and queues the bundle in a DEPTH-entry FIFO.
// Latency: one cycle from an accepted push to out_valid when the buffer is empty.
// Backpressure: in_ready follows the registered fill count only; a pop frees space one cycle later.
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  decode_pipe_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] BEQ_OP      = 4'd4;
  localparam logic [3:0] BNE_OP      = 4'd5;
  localparam logic [3:0] BLT_OP      = 4'd6;
  localparam logic [3:0] BGE_OP      = 4'd7;
  localparam logic [3:0] BLTU_OP     = 4'd8;
  localparam logic [3:0] BGEU_OP     = 4'd9;
  localparam logic [3:0] ALU_UNKNOWN = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            branch;
    logic            jump;
    logic            mem_read;
    logic            mem_write;
    logic            memtoreg;
    logic            alu_src;
    logic            we;
    logic [1:0]      pc_sel;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  logic [31:0]     instr;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t          dec;
  entry_t          head;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  // Immediate formats, all sign-extended from instr[31]; B and J keep bit 0 clear.
  assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode the offered instruction; anything unsupported collapses to an illegal bundle.
  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.alu_op = ALU_ADD;
    case (opc)
      OPC_R: begin
        dec.we = 1'b1;
        if (f7 == 7'b0000000 && f3 == 3'b000)      dec.alu_op = ALU_ADD;
        else if (f7 == 7'b0100000 && f3 == 3'b000) dec.alu_op = ALU_SUB;
        else if (f7 == 7'b0000000 && f3 == 3'b111) dec.alu_op = ALU_AND;
        else if (f7 == 7'b0000000 && f3 == 3'b110) dec.alu_op = ALU_OR;
        else                                       dec.illegal = 1'b1;
      end
      OPC_IMM: begin
        dec.we      = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_i;
        case (f3)
          3'b000:  dec.alu_op = ALU_ADD;
          3'b111:  dec.alu_op = ALU_AND;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.we       = 1'b1;
        dec.alu_src  = 1'b1;
        dec.mem_read = 1'b1;
        dec.memtoreg = 1'b1;
        dec.imm      = imm_i;
      end
      OPC_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.pc_sel = 2'b01;
        dec.imm    = imm_b;
        case (f3)
          3'b000:  dec.alu_op = BEQ_OP;
          3'b001:  dec.alu_op = BNE_OP;
          3'b100:  dec.alu_op = BLT_OP;
          3'b101:  dec.alu_op = BGE_OP;
          3'b110:  dec.alu_op = BLTU_OP;
          3'b111:  dec.alu_op = BGEU_OP;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.jump   = 1'b1;
        dec.we     = 1'b1;
        dec.pc_sel = 2'b10;
        dec.imm    = imm_j;
      end
      OPC_JALR: begin
        dec.jump    = 1'b1;
        dec.we      = 1'b1;
        dec.alu_src = 1'b1;
        dec.pc_sel  = 2'b11;
        dec.imm     = imm_i;
        if (f3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.we      = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions keep pc and register fields but nothing that could cause a side effect.
    if (dec.illegal) begin
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.memtoreg  = 1'b0;
      dec.alu_src   = 1'b0;
      dec.we        = 1'b0;
      dec.pc_sel    = 2'b00;
      dec.alu_op    = ALU_UNKNOWN;
      dec.imm       = '0;
    end
  end

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  // Next pointer/count; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy state; async reset empties the buffer without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: the head view is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign bus.in_ready  = (count_q < FULL_CNT);
  assign bus.out_valid = (count_q != '0);
  assign head          = bus.out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.out_pc           = head.pc;
  assign bus.out_rd           = head.rd;
  assign bus.out_rs1          = head.rs1;
  assign bus.out_rs2          = head.rs2;
  assign bus.out_branch       = head.branch;
  assign bus.out_jump         = head.jump;
  assign bus.out_mem_read     = head.mem_read;
  assign bus.out_mem_write    = head.mem_write;
  assign bus.out_memtoreg     = head.memtoreg;
  assign bus.out_alu_src      = head.alu_src;
  assign bus.out_write_enable = head.we;
  assign bus.out_pc_sel       = head.pc_sel;
  assign bus.out_alu_op       = head.alu_op;
  assign bus.out_imm          = head.imm;
  assign bus.out_illegal      = head.illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios followed by random traffic against a queue-based reference.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: out_ready and flush are driven randomly in the random phase.
module tb_decode_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3;
  localparam logic [3:0] A_BEQ = 4'd4, A_BNE = 4'd5, A_BLT = 4'd6, A_BGE = 4'd7;
  localparam logic [3:0] A_BLTU = 4'd8, A_BGEU = 4'd9, A_UNK = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        br, jmp, mr, mw, m2r, asrc, we;
    logic [1:0]  psel;
    logic [3:0]  aop;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t model_q[$];

  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(XLEN)) bus ();
  decode_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder written from the instruction-set rules using integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    int          op, f3, f7, sgn;
    logic [31:0] ii, si, bi, ui, ji;
    logic [3:0]  bmap [8];
    bmap = '{A_BEQ, A_BNE, A_UNK, A_UNK, A_BLT, A_BGE, A_BLTU, A_BGEU};
    op  = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    sgn = ins[31] ? -1 : 0;
    ii  = (sgn << 11) | int'(ins[30:20]);
    si  = (sgn << 11) | (int'(ins[30:25]) << 5) | int'(ins[11:7]);
    bi  = (sgn << 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
    ui  = ins & 32'hFFFF_F000;
    ji  = (sgn << 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
    e     = '0;
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.aop = A_ADD;
    case (op)
      'h33: begin
        e.we = 1'b1;
        if (f7 == 0 && f3 == 0)       e.aop = A_ADD;
        else if (f7 == 32 && f3 == 0) e.aop = A_SUB;
        else if (f7 == 0 && f3 == 7)  e.aop = A_AND;
        else if (f7 == 0 && f3 == 6)  e.aop = A_OR;
        else                          e.ill = 1'b1;
      end
      'h13: begin
        e.we = 1'b1; e.asrc = 1'b1; e.imm = ii;
        if (f3 == 0)      e.aop = A_ADD;
        else if (f3 == 7) e.aop = A_AND;
        else if (f3 == 6) e.aop = A_OR;
        else              e.ill = 1'b1;
      end
      'h03: begin e.we = 1'b1; e.asrc = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.imm = ii; end
      'h23: begin e.asrc = 1'b1; e.mw = 1'b1; e.imm = si; end
      'h63: begin
        e.br = 1'b1; e.psel = 2'b01; e.imm = bi; e.aop = bmap[f3];
        if (f3 == 2 || f3 == 3) e.ill = 1'b1;
      end
      'h6F: begin e.jmp = 1'b1; e.we = 1'b1; e.psel = 2'b10; e.imm = ji; end
      'h67: begin
        if (f3 == 0) begin e.jmp = 1'b1; e.we = 1'b1; e.asrc = 1'b1; e.psel = 2'b11; e.imm = ii; end
        else e.ill = 1'b1;
      end
      'h37, 'h17: begin e.we = 1'b1; e.asrc = 1'b1; e.imm = ui; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.br = 0; e.jmp = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.asrc = 0; e.we = 0;
      e.psel = 2'b00; e.aop = A_UNK; e.imm = '0;
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.pc  = bus.out_pc;          o.rd  = bus.out_rd;
    o.rs1 = bus.out_rs1;         o.rs2 = bus.out_rs2;
    o.br  = bus.out_branch;      o.jmp = bus.out_jump;
    o.mr  = bus.out_mem_read;    o.mw  = bus.out_mem_write;
    o.m2r = bus.out_memtoreg;    o.asrc = bus.out_alu_src;
    o.we  = bus.out_write_enable; o.psel = bus.out_pc_sel;
    o.aop = bus.out_alu_op;      o.imm = bus.out_imm;
    o.ill = bus.out_illegal;
    return o;
  endfunction

  task automatic chk_head(input string tag, input exp_t e);
    exp_t o;
    o = observe();
    chk({tag, "_pc"},   128'(o.pc), 128'(e.pc));
    chk({tag, "_regs"}, 128'({o.rd, o.rs1, o.rs2}), 128'({e.rd, e.rs1, e.rs2}));
    chk({tag, "_ctl"},  128'({o.br, o.jmp, o.mr, o.mw, o.m2r, o.asrc, o.we, o.psel}),
                        128'({e.br, e.jmp, e.mr, e.mw, e.m2r, e.asrc, e.we, e.psel}));
    chk({tag, "_aop"},  128'(o.aop), 128'(e.aop));
    chk({tag, "_imm"},  128'(o.imm), 128'(e.imm));
    chk({tag, "_ill"},  128'(o.ill), 128'(e.ill));
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      6: begin
        w[6:0] = 7'h67;
        if ($urandom_range(0, 1) == 1) w[14:12] = 3'b000;
      end
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      default: w = w;
    endcase
    return w;
  endfunction

  initial begin
    logic push_m, pop_m;
    exp_t e;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1'b1));
    chk_head("rst_bundle", exp_t'('0));
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,10 at PC 0x100.
    bus.in_valid = 1'b1; bus.in_instr = 32'h00A0_0093; bus.in_pc = 32'h100;
    tick();
    bus.in_valid = 1'b0;
    chk("addi_valid", 128'(bus.out_valid), 128'(1'b1));
    chk("addi_imm",   128'(bus.out_imm), 128'(32'd10));
    chk("addi_src_we", 128'({bus.out_alu_src, bus.out_write_enable}), 128'(2'b11));
    chk("addi_rd",    128'(bus.out_rd), 128'(5'd1));
    chk("addi_aop",   128'(bus.out_alu_op), 128'(A_ADD));
    chk_head("addi_ref", ref_decode(32'h00A0_0093, 32'h100));
    bus.out_ready = 1'b1;
    tick();
    chk("addi_popped", 128'(bus.out_valid), 128'(1'b0));

    // beq x0,x0,-4: backward branch offset.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'hFE00_0EE3; bus.in_pc = 32'h180;
    tick();
    bus.in_valid = 1'b0;
    chk("beq_br_psel", 128'({bus.out_branch, bus.out_pc_sel}), 128'(3'b101));
    chk("beq_aop", 128'(bus.out_alu_op), 128'(A_BEQ));
    chk("beq_imm", 128'(bus.out_imm), 128'(32'hFFFF_FFFC));
    bus.out_ready = 1'b1;
    tick();

    // Fill with the consumer stalled, overflow push ignored, then pop with a competing push.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0113; bus.in_pc = 32'h200;
    tick();
    bus.in_pc = 32'h204;
    tick();
    chk("full_in_ready", 128'(bus.in_ready), 128'(1'b0));
    bus.in_pc = 32'h208;
    tick();
    chk("full_hold_pc", 128'(bus.out_pc), 128'(32'h200));
    chk("full_still", 128'(bus.in_ready), 128'(1'b0));
    bus.in_pc = 32'h20C; bus.out_ready = 1'b1;
    tick();
    chk("pop1_pc", 128'(bus.out_pc), 128'(32'h204));
    chk("pop1_in_ready", 128'(bus.in_ready), 128'(1'b1));
    bus.in_valid = 1'b0;
    tick();
    chk("drained", 128'(bus.out_valid), 128'(1'b0));

    // Flush with two buffered and a push offered, then with one buffered and a pop requested.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h300;
    tick();
    bus.in_pc = 32'h304;
    tick();
    bus.flush = 1'b1; bus.in_pc = 32'h308;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("flush_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();
    chk("flush_dropped", 128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1; bus.in_pc = 32'h310;
    tick();
    bus.flush = 1'b1; bus.in_pc = 32'h314; bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("flush1_valid", 128'(bus.out_valid), 128'(1'b0));

    // All-ones word is illegal; then reset lands mid-cycle with entries buffered.
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFFF_FFFF; bus.in_pc = 32'h400;
    tick();
    bus.in_instr = 32'h00A0_0093; bus.in_pc = 32'h404;
    chk("ill_flag", 128'(bus.out_illegal), 128'(1'b1));
    chk("ill_aop",  128'(bus.out_alu_op), 128'(A_UNK));
    chk("ill_imm",  128'(bus.out_imm), 128'(32'h0));
    chk("ill_rd",   128'(bus.out_rd), 128'(5'd31));
    chk_head("ill_ref", ref_decode(32'hFFFF_FFFF, 32'h400));
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("async_rst_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("async_rst_ill", 128'(bus.out_illegal), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      chk("rnd_out_valid", 128'(bus.out_valid), 128'(model_q.size() != 0));
      chk("rnd_in_ready",  128'(bus.in_ready),  128'(model_q.size() < DEPTH));
      if (model_q.size() != 0) chk_head("rnd_head", model_q[0]);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      bus.flush     = ($urandom_range(0, 24) == 0);
      bus.in_instr  = gen_instr();
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      push_m = bus.in_valid && (model_q.size() < DEPTH) && !bus.flush;
      pop_m  = bus.out_ready && (model_q.size() != 0) && !bus.flush;
      e = ref_decode(bus.in_instr, bus.in_pc);
      if (bus.flush) model_q.delete();
      else begin
        if (pop_m)  void'(model_q.pop_front());
        if (push_m) model_q.push_back(e);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
